// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stream_pkg
//  Brief    : Shared link-word type, default sizes and output-state encoding
//             for the operator stream transmit/receive shells.
//  Revision : 1.0  initial release
// ============================================================================
package stream_pkg;

    localparam int c_PAYLOAD_BITS   = 128;
    localparam int c_NUM_ADDR_BITS  = 4;

    typedef logic [c_PAYLOAD_BITS-1:0] link_word_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } out_state_e;

endpackage
`default_nettype wire

// File: rtl/stream_tx_shell_if.sv
`default_nettype none
// ============================================================================
//  Module   : stream_tx_shell_if
//  Brief    : Upstream val/ready port plus outbound link of the TX shell.
//             master = the shell, slave = its environment.
//  Revision : 1.0  initial release
// ============================================================================
interface stream_tx_shell_if
    import stream_pkg::*;
#(
    parameter int PAYLOAD_BITS = c_PAYLOAD_BITS
) ();

    logic [PAYLOAD_BITS-1:0] din;
    logic                    val_in;
    logic                    ready_upward;
    logic [PAYLOAD_BITS-1:0] dout;
    logic                    val_out;
    logic                    ready_downward;
    logic                    prog_full;
    logic                    overflow;

    modport master (
        input  din, val_in, ready_downward,
        output ready_upward, dout, val_out, prog_full, overflow
    );

    modport slave (
        output din, val_in, ready_downward,
        input  ready_upward, dout, val_out, prog_full, overflow
    );

endinterface
`default_nettype wire

// File: rtl/stream_tx_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module   : stream_tx_fifo_mem
//  Brief    : Register-array storage, one write port and an async head read.
//  Revision : 1.0  initial release
// ============================================================================
module stream_tx_fifo_mem #(
    parameter int PAYLOAD_BITS  = 128,
    parameter int NUM_ADDR_BITS = 4
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [NUM_ADDR_BITS-1:0] wr_ptr,
    input  wire logic [PAYLOAD_BITS-1:0]  wdata,
    input  wire logic [NUM_ADDR_BITS-1:0] rd_ptr,
    output logic      [PAYLOAD_BITS-1:0]  rdata
);

    logic [PAYLOAD_BITS-1:0] r_mem [2**NUM_ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/stream_tx_shell.sv
`default_nettype none
// ============================================================================
//  Module   : stream_tx_shell
//  Brief    : Transmit shell: buffers operator words in a FWFT register FIFO
//             and drives the outbound link only when the receiver is ready.
//             Optional macro STREAM_TX_WORD_CNT_EN adds a 32-bit pop counter.
//  Revision : 1.0  initial release
// ============================================================================
module stream_tx_shell
    import stream_pkg::*;
#(
    parameter int PAYLOAD_BITS     = c_PAYLOAD_BITS,
    parameter int NUM_ADDR_BITS    = c_NUM_ADDR_BITS,
    parameter int PROG_FULL_THRESH = 12
) (
    input  wire logic          clk,
    input  wire logic          reset,
    stream_tx_shell_if.master  link
`ifdef STREAM_TX_WORD_CNT_EN
    ,
    output logic [31:0]        tx_word_cnt
`endif
);

    localparam int                   c_DEPTH     = 2**NUM_ADDR_BITS;
    localparam logic [NUM_ADDR_BITS:0] c_DEPTH_CNT = (NUM_ADDR_BITS+1)'(c_DEPTH);
    localparam logic [NUM_ADDR_BITS:0] c_THRESH    = (NUM_ADDR_BITS+1)'(PROG_FULL_THRESH);
    localparam logic [NUM_ADDR_BITS:0] c_ONE       = (NUM_ADDR_BITS+1)'(1);

    logic [1:0]               r_rst_sync;
    logic                     w_rst_n;
    logic [NUM_ADDR_BITS-1:0] r_wr_ptr;
    logic [NUM_ADDR_BITS-1:0] r_rd_ptr;
    logic [NUM_ADDR_BITS:0]   r_count;
    logic [NUM_ADDR_BITS:0]   w_count_nxt;
    logic                     r_prog_full;
    logic                     r_overflow;
    out_state_e               r_state;
    out_state_e               w_state_nxt;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_active;
    logic [PAYLOAD_BITS-1:0]  w_head;

    // Assert immediately, release two clocks after the external reset lifts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_full            = (r_count == c_DEPTH_CNT);
    assign link.ready_upward = w_rst_n && !w_full;
    assign w_push            = link.val_in && link.ready_upward;
    assign w_active          = (r_state == ACTIVE);
    assign link.val_out      = w_active && link.ready_downward;
    assign w_pop             = link.val_out;
    assign link.dout         = w_active ? w_head : '0;
    assign link.prog_full    = r_prog_full;
    assign link.overflow     = r_overflow;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_ONE;
            2'b01:   w_count_nxt = r_count - c_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_push) w_state_nxt = ACTIVE;
            ACTIVE:  if (w_pop && !w_push && (r_count == c_ONE)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_prog_full <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count     <= w_count_nxt;
            r_prog_full <= (w_count_nxt >= c_THRESH);
            // Word offered while full is dropped; the flag is sticky until reset.
            if (link.val_in && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    stream_tx_fifo_mem #(
        .PAYLOAD_BITS  (PAYLOAD_BITS),
        .NUM_ADDR_BITS (NUM_ADDR_BITS)
    ) u_mem (
        .clk    (clk),
        .we     (w_push),
        .wr_ptr (r_wr_ptr),
        .wdata  (link.din),
        .rd_ptr (r_rd_ptr),
        .rdata  (w_head)
    );

`ifdef STREAM_TX_WORD_CNT_EN
    logic [31:0] r_word_cnt;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_word_cnt <= 32'd0;
        end else if (w_pop) begin
            r_word_cnt <= r_word_cnt + 32'd1;
        end
    end

    assign tx_word_cnt = r_word_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_tx_shell.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_tx_shell
//  Brief    : Scoreboard bench for stream_tx_shell (honours STREAM_TX_WORD_CNT_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_stream_tx_shell;
    import stream_pkg::*;

    logic clk = 1'b0;
    logic reset;

    stream_tx_shell_if #(.PAYLOAD_BITS(c_PAYLOAD_BITS)) lnk ();

`ifdef STREAM_TX_WORD_CNT_EN
    logic [31:0] tx_word_cnt;
`endif

    stream_tx_shell #(
        .PAYLOAD_BITS     (c_PAYLOAD_BITS),
        .NUM_ADDR_BITS    (c_NUM_ADDR_BITS),
        .PROG_FULL_THRESH (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .link  (lnk)
`ifdef STREAM_TX_WORD_CNT_EN
        ,
        .tx_word_cnt (tx_word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_cmp;
    int          n_fail;
    int          m_count;
    bit          m_ovf;
    bit          m_push;
    bit          m_pop;
    bit          sb_en;
    link_word_t  exp_q[$];
    link_word_t  exp_w;

    task automatic test_reset;
        reset = 1'b1;
        lnk.val_in = 1'b0;
        lnk.din = '0;
        lnk.ready_downward = 1'b1;
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (lnk.ready_upward !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", lnk.ready_upward); end
        n_cmp++; if (lnk.val_out !== 1'b0) begin n_fail++; $display("FAIL rst_val_out: got %b expected 0", lnk.val_out); end
        n_cmp++; if (lnk.dout !== '0) begin n_fail++; $display("FAIL rst_dout: got %0h expected 0", lnk.dout); end
        n_cmp++; if (lnk.prog_full !== 1'b0) begin n_fail++; $display("FAIL rst_prog_full: got %b expected 0", lnk.prog_full); end
        n_cmp++; if (lnk.overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", lnk.overflow); end
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (lnk.ready_upward !== 1'b0) begin n_fail++; $display("FAIL sync_ready_early: got %b expected 0", lnk.ready_upward); end
        @(negedge clk);
        n_cmp++; if (lnk.ready_upward !== 1'b1) begin n_fail++; $display("FAIL sync_ready: got %b expected 1", lnk.ready_upward); end
        n_cmp++; if (lnk.val_out !== 1'b0) begin n_fail++; $display("FAIL idle_val_out: got %b expected 0", lnk.val_out); end
        n_cmp++; if (lnk.dout !== '0) begin n_fail++; $display("FAIL idle_dout: got %0h expected 0", lnk.dout); end
        m_count = 0;
        m_ovf = 1'b0;
        sb_en = 1'b1;
    endtask

    task automatic test_pass_through;
        bit exp_v;
        lnk.ready_downward = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i < 3) begin
                lnk.val_in = 1'b1;
                lnk.din = link_word_t'(i + 1);
            end else begin
                lnk.val_in = 1'b0;
            end
            @(negedge clk);
            exp_v = (i >= 1) && (i <= 3);
            n_cmp++; if (lnk.val_out !== exp_v) begin n_fail++; $display("FAIL pass_val_out[%0d]: got %b expected %b", i, lnk.val_out, exp_v); end
        end
    endtask

    task automatic test_fill_overflow;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1;
            lnk.ready_downward = 1'b0;
            if (k < 17) begin
                lnk.val_in = 1'b1;
                lnk.din = (k < 16) ? link_word_t'(16 + k) : link_word_t'(32'hEE);
            end else begin
                lnk.val_in = 1'b0;
            end
            @(negedge clk);
            if (k <= 16) begin
                n_cmp++; if (lnk.prog_full !== (k >= 12)) begin n_fail++; $display("FAIL fill_prog_full[%0d]: got %b expected %b", k, lnk.prog_full, (k >= 12)); end
            end
            if (k == 16) begin
                n_cmp++; if (lnk.ready_upward !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b expected 0", lnk.ready_upward); end
            end
            if (k == 17) begin
                n_cmp++; if (lnk.overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set: got %b expected 1", lnk.overflow); end
            end
        end
        @(posedge clk); #1 lnk.ready_downward = 1'b1;
        @(negedge clk);
        n_cmp++; if (lnk.ready_upward !== 1'b0) begin n_fail++; $display("FAIL pop_same_cycle_ready: got %b expected 0", lnk.ready_upward); end
        @(negedge clk);
        n_cmp++; if (lnk.ready_upward !== 1'b1) begin n_fail++; $display("FAIL ready_after_pop: got %b expected 1", lnk.ready_upward); end
        repeat (16) @(negedge clk);
        n_cmp++; if (lnk.val_out !== 1'b0) begin n_fail++; $display("FAIL drain_val_out: got %b expected 0", lnk.val_out); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL drain_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back;
        int drained;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            lnk.ready_downward = 1'b0;
            lnk.val_in = 1'b1;
            lnk.din = link_word_t'(32'h100 + k);
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            lnk.ready_downward = 1'b1;
            lnk.val_in = 1'b1;
            lnk.din = link_word_t'(32'h105 + k);
            @(negedge clk);
            n_cmp++; if (lnk.val_out !== 1'b1 || lnk.ready_upward !== 1'b1) begin n_fail++; $display("FAIL steady[%0d]: got val_out=%b ready=%b expected 1/1", k, lnk.val_out, lnk.ready_upward); end
        end
        @(posedge clk); #1 lnk.val_in = 1'b0;
        drained = 0;
        repeat (8) begin
            @(negedge clk);
            if (lnk.val_out) drained++;
        end
        n_cmp++; if (drained != 5) begin n_fail++; $display("FAIL steady_occupancy: got %0d expected 5", drained); end
    endtask

    task automatic test_reset_mid_burst;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            lnk.ready_downward = 1'b0;
            lnk.val_in = 1'b1;
            lnk.din = link_word_t'(32'h300 + k);
        end
        @(posedge clk); #1;
        lnk.val_in = 1'b0;
        lnk.ready_downward = 1'b1;
        #1;
        n_cmp++; if (lnk.val_out !== 1'b1) begin n_fail++; $display("FAIL mid_val_out_pre: got %b expected 1", lnk.val_out); end
        sb_en = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (lnk.val_out !== 1'b0) begin n_fail++; $display("FAIL mid_val_out_async: got %b expected 0", lnk.val_out); end
        n_cmp++; if (lnk.dout !== '0) begin n_fail++; $display("FAIL mid_dout_async: got %0h expected 0", lnk.dout); end
        n_cmp++; if (lnk.ready_upward !== 1'b0) begin n_fail++; $display("FAIL mid_ready_async: got %b expected 0", lnk.ready_upward); end
        @(posedge clk); #3 reset = 1'b1;
        exp_q.delete();
        m_count = 0;
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (lnk.ready_upward !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b expected 1", lnk.ready_upward); end
        n_cmp++; if (lnk.val_out !== 1'b0) begin n_fail++; $display("FAIL post_rst_val_out: got %b expected 0", lnk.val_out); end
        n_cmp++; if (lnk.overflow !== 1'b0) begin n_fail++; $display("FAIL post_rst_overflow: got %b expected 0", lnk.overflow); end
        n_cmp++; if (lnk.prog_full !== 1'b0) begin n_fail++; $display("FAIL post_rst_prog_full: got %b expected 0", lnk.prog_full); end
        sb_en = 1'b1;
    endtask

`ifdef STREAM_TX_WORD_CNT_EN
    task automatic test_word_cnt;
        int pushed;
        int cyc;
        bit vi;
        n_cmp++; if (tx_word_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_reset: got %0d expected 0", tx_word_cnt); end
        pushed = 0;
        cyc = 0;
        while (pushed < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            vi = 1'($urandom_range(0, 1));
            lnk.val_in = vi;
            lnk.din = link_word_t'(32'h2000 + pushed);
            lnk.ready_downward = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (vi && lnk.ready_upward) pushed++;
            cyc++;
        end
        n_cmp++; if (pushed != 1000) begin n_fail++; $display("FAIL cnt_timeout: got %0d expected 1000", pushed); end
        @(posedge clk); #1;
        lnk.val_in = 1'b0;
        lnk.ready_downward = 1'b1;
        repeat (20) @(negedge clk);
        n_cmp++; if (tx_word_cnt !== 32'd1000) begin n_fail++; $display("FAIL cnt_total: got %0d expected 1000", tx_word_cnt); end
        @(posedge clk); #1 force dut.r_word_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1 release dut.r_word_cnt;
        lnk.val_in = 1'b1;
        lnk.din = link_word_t'(32'h5A5A);
        @(posedge clk); #1 lnk.val_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx_word_cnt !== 32'd0) begin n_fail++; $display("FAIL cnt_wrap: got %0h expected 0", tx_word_cnt); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_fail = 0;
        m_count = 0;
        m_ovf = 1'b0;
        sb_en = 1'b0;
        fork
            // Reference FIFO model: checks handshake/flags every cycle and
            // pops expected words as the link transfers them.
            forever begin
                @(negedge clk);
                if (sb_en) begin
                    m_pop  = (m_count != 0) && lnk.ready_downward;
                    m_push = lnk.val_in && (m_count != 16);
                    n_cmp++; if (lnk.val_out !== m_pop) begin n_fail++; $display("FAIL sb_val_out: got %b expected %b", lnk.val_out, m_pop); end
                    n_cmp++; if (lnk.ready_upward !== (m_count != 16)) begin n_fail++; $display("FAIL sb_ready: got %b expected %b", lnk.ready_upward, (m_count != 16)); end
                    n_cmp++; if (lnk.prog_full !== (m_count >= 12)) begin n_fail++; $display("FAIL sb_prog_full: got %b expected %b", lnk.prog_full, (m_count >= 12)); end
                    n_cmp++; if (lnk.overflow !== m_ovf) begin n_fail++; $display("FAIL sb_overflow: got %b expected %b", lnk.overflow, m_ovf); end
                    if (m_pop) begin
                        exp_w = exp_q.pop_front();
                        n_cmp++; if (lnk.dout !== exp_w) begin n_fail++; $display("FAIL sb_dout: got %0h expected %0h", lnk.dout, exp_w); end
                    end else if (m_count == 0) begin
                        n_cmp++; if (lnk.dout !== '0) begin n_fail++; $display("FAIL sb_empty_dout: got %0h expected 0", lnk.dout); end
                    end
                    if (lnk.val_in && m_count == 16) m_ovf = 1'b1;
                    if (m_push) exp_q.push_back(lnk.din);
                    m_count = m_count + int'(m_push) - int'(m_pop);
                end
            end
        join_none

        test_reset();
        test_pass_through();
        test_fill_overflow();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef STREAM_TX_WORD_CNT_EN
        test_word_cnt();
`endif
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_tx_shell.md
Name: stream_tx_shell

Overview:
- Transmit-side shell for the operator stream link.
- Accepts payload words from a page operator's output port (val/ready), buffers them in an internal register FIFO, and drives the outbound link toward a downstream receive shell.
- Link rule: val_out is asserted only in a cycle where ready_downward is high. Every cycle with val_out=1 is a completed transfer.
- Never overruns the receiver, because the receiver's ready reflects its FIFO not-full state.

Parameters:
- PAYLOAD_BITS, 128, width of one stream word.
- NUM_ADDR_BITS, 4, log2 of FIFO depth (depth = 2**NUM_ADDR_BITS = 16).
- PROG_FULL_THRESH, 12, occupancy at or above which prog_full asserts; legal range 1..depth.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- din  input  PAYLOAD_BITS  word from the upstream operator.
- val_in  input  1  upstream word valid.
- ready_upward  output  1  shell can accept a word this cycle.
- dout  output  PAYLOAD_BITS  outbound link word.
- val_out  output  1  outbound word valid; a transfer occurs every cycle this is 1.
- ready_downward  input  1  downstream receiver can accept.
- prog_full  output  1  occupancy >= PROG_FULL_THRESH.
- overflow  output  1  sticky; val_in was seen while full.

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-to-clk deassert via internal 2-flop synchronizer):
  - Read and write pointers = 0, count = 0, overflow = 0.
  - Storage contents are don't-care.
  - During reset: ready_upward=0, val_out=0, dout=0, prog_full=0.
  - Reset mid-operation discards all buffered words immediately; no partial transfer is emitted.
- Write:
  - ready_upward = ~full (combinational from count, registered state only).
  - push = val_in && ready_upward; the word is stored at wr_ptr, and wr_ptr increments modulo depth.
- Overflow: val_in && full sets overflow=1; the word is dropped and the FIFO is unchanged. overflow clears only on reset.
- Read:
  - FWFT head. dout = mem[rd_ptr] when count != 0, else all zeros.
  - val_out = (count != 0) && ready_downward (combinational).
  - pop = val_out; rd_ptr increments modulo depth.
- Latency: a word pushed in cycle N is first visible on dout/val_out in cycle N+1. There is no same-cycle bypass, including when empty.
- Count arithmetic (NUM_ADDR_BITS+1 bits; full = count==depth, empty = count==0):
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged
- Pointers wrap naturally at depth; there is no separate wrap flag.
- Boundary conditions:
  - Full: ready_upward=0. A pop in the same cycle does not re-enable the push that cycle; ready_upward rises next cycle.
  - Empty: val_out=0 regardless of ready_downward, and dout=0.
  - ready_downward low: head is held, dout stays stable, no pop.
- prog_full is registered from next-count, so it asserts in the cycle count reaches the threshold.
- State machine for the output side:
  - IDLE (count==0) -> ACTIVE when count becomes nonzero.
  - ACTIVE -> IDLE when the last word pops with no simultaneous push.
  - ACTIVE holds while ready_downward=0.
  - State is exposed only through val_out/dout.

Optional Feature:
- STREAM_TX_WORD_CNT_EN
- Defined: adds output port tx_word_cnt [31:0]. It increments on every pop, wraps 0xFFFFFFFF -> 0, and resets to 0.
- Undefined: the port and counter do not exist; the port list is exactly as above.

Decomposition:
- Shared package stream_pkg holds:
  - default PAYLOAD_BITS and NUM_ADDR_BITS;
  - the link-word typedef (logic [PAYLOAD_BITS-1:0]);
  - the output state enum {IDLE, ACTIVE}.
- The same package is used by the receive shell.
- One sub-module, stream_tx_fifo_mem: register array with a single write port and an async-read head port (rd_ptr, wr_ptr, we, wdata, rdata).
- Pointer, count, flag and handshake logic stay in stream_tx_shell.

Test Plan:
- Reset then idle: hold reset=0 5 cycles, release, with val_in=0 and ready_downward=1 -> val_out=0, dout=0, ready_upward=1 from first post-sync cycle, prog_full=0.
- Pass-through: push 0x1,0x2,0x3 on consecutive cycles with ready_downward=1 -> val_out high on cycles N+1..N+3, dout 0x1,0x2,0x3 in order, then val_out=0.
- Backpressure/fill: ready_downward=0, push 16 words 0x10..0x1F -> prog_full asserts on the 12th push, ready_upward=0 after the 16th. A 17th val_in sets overflow=1 and the FIFO still holds 0x10..0x1F. Then ready_downward=1 -> 16 words emitted in order, with ready_upward high one cycle after the first pop.
- Simultaneous push/pop at steady state with count=5: count stays 5 for 20 cycles and output order matches input order.
- Reset mid-burst: with 8 words queued, pulse reset low for 1 cycle between clock edges -> val_out drops asynchronously, FIFO empty afterward, overflow=0.
- With STREAM_TX_WORD_CNT_EN: 1000 random-gap transfers -> tx_word_cnt=1000. Preload of 0xFFFFFFFF via force followed by one pop gives tx_word_cnt=0.
